// File: rtl/edge_frame_capture.sv
// Thresholds the filtered edge stream to 1 bit/pixel and packs 8 pixels per byte into a frame buffer.
// Define EDGE_CAPTURE_CONT_EN for continuous capture; the default is single-shot per i_arm.
module edge_frame_capture #(
    parameter int WIDTH   = 8,
    parameter int H_RES   = 170,
    parameter int V_RES   = 120,
    parameter int EDGE_TH = 128,
    parameter int ADDR_W  = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_vsync,
    input  logic              i_hsync,
    input  logic              i_de,
    input  logic [WIDTH-1:0]  i_data,
    input  logic              i_arm,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_frame_err,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    output logic [15:0]       o_edge_cnt
);
    localparam int BPL = (H_RES + 7) / 8;
    localparam int XW  = $clog2(H_RES + 1);
    localparam int YW  = $clog2(V_RES + 1);
    localparam logic [XW-1:0]    X_END  = XW'(H_RES);
    localparam logic [XW-1:0]    X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0]    Y_LAST = YW'(V_RES - 1);
    localparam logic [WIDTH-1:0] TH     = WIDTH'(EDGE_TH);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [7:0]        pack_q, pack_d;
    logic              vs_prev_q, de_prev_q;
    logic              busy_q, busy_d, done_q, done_d;
    logic              err_q, err_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              vs_rise, de_fall, pix;

    // Line sync carries no information beyond what de already gives.
    logic unused_hsync;
    assign unused_hsync = i_hsync;

    function automatic logic [ADDR_W-1:0] byte_addr(input logic [YW-1:0] y, input logic [XW-1:0] x);
        return ADDR_W'(int'(y) * BPL + int'(x >> 3));
    endfunction

    assign vs_rise = i_vsync & ~vs_prev_q;
    assign de_fall = de_prev_q & ~i_de;

    // NOTE: every *_d gets a default first so no path through the case leaves a latch.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        pack_d  = pack_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pix     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_arm) begin
                    state_d = WAIT_VS;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            WAIT_VS: begin
                if (vs_rise) begin
                    state_d = CAPTURE;
                    x_d     = '0;
                    y_d     = '0;
                    pack_d  = '0;
`ifdef EDGE_CAPTURE_CONT_EN
                    err_d   = 1'b0;
                    cnt_d   = '0;
`endif
                end
            end
            CAPTURE: begin
                if (i_de) begin
                    if (x_q < X_END) begin
                        pix              = (i_data >= TH);
                        pack_d[x_q[2:0]] = pix;
                        if (pix && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                        if (x_q[2:0] == 3'd7 || x_q == X_LAST) begin
                            we_d    = 1'b1;
                            addr_d  = byte_addr(y_q, x_q);
                            wdata_d = pack_d;
                            pack_d  = '0;
                        end
                        x_d = x_q + XW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (de_fall) begin
                    if (x_q < X_END) begin
                        err_d = 1'b1;
                        if (x_q[2:0] != 3'd0) begin
                            we_d    = 1'b1;
                            addr_d  = byte_addr(y_q, x_q);
                            wdata_d = pack_q;
                        end
                    end
                    x_d    = '0;
                    y_d    = y_q + YW'(1);
                    pack_d = '0;
                    if (y_q == Y_LAST) state_d = DONE;
                end
                // Early vsync sees the state left by any same-cycle line end, so it never double-flushes.
                if (vs_rise && state_d != DONE) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                    if (x_d < X_END && x_d[2:0] != 3'd0) begin
                        we_d    = 1'b1;
                        addr_d  = byte_addr(y_d, x_d);
                        wdata_d = pack_d;
                    end
                end
            end
            DONE: begin
`ifdef EDGE_CAPTURE_CONT_EN
                state_d = WAIT_VS;
`else
                if (i_arm) begin
                    state_d = WAIT_VS;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == WAIT_VS) || (state_d == CAPTURE);
        done_d = (state_d == DONE);
    end

    // NOTE: non-blocking assignments keep every flop sampling the pre-edge value of its peers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            pack_q    <= '0;
            vs_prev_q <= 1'b0;
            de_prev_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            pack_q    <= pack_d;
            vs_prev_q <= i_vsync;
            de_prev_q <= i_de;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_frame_err = err_q;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_edge_cnt  = cnt_q;
endmodule

// File: tb/tb_edge_frame_capture.sv
// Directed bench for edge_frame_capture: full/pattern/short/long/early-vsync frames and reset abort.
// Builds with EDGE_CAPTURE_CONT_EN defined run the continuous-capture sequence instead.
module tb_edge_frame_capture;
    localparam int H_RES = 170;
    localparam int V_RES = 120;
    localparam int BPL   = 22;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_vsync = 1'b0, i_hsync = 1'b0, i_de = 1'b0, i_arm = 1'b0;
    logic [7:0]  i_data = '0;
    logic        o_busy, o_done, o_frame_err, o_mem_we;
    logic [11:0] o_mem_addr;
    logic [7:0]  o_mem_wdata;
    logic [15:0] o_edge_cnt;

    edge_frame_capture dut (
        .clk(clk), .rstn(rstn), .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de),
        .i_data(i_data), .i_arm(i_arm), .o_busy(o_busy), .o_done(o_done),
        .o_frame_err(o_frame_err), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_edge_cnt(o_edge_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected byte for each write, derived from the stimulus pattern of the frame kind.
    function automatic logic [7:0] exp_byte(input int kind, input int addr);
        int b;
        b = addr % BPL;
        if (kind == 0) return (b == BPL - 1) ? 8'h03 : 8'hFF;
        if (addr == 0) return 8'h01;
        if (addr == 1) return 8'h02;
        if (addr == 5 * BPL + 12) return 8'h0F;
        return 8'h00;
    endfunction

    function automatic logic [7:0] pix_val(input int kind, input int line, input int x);
        if (kind == 0) return 8'hFF;
        if (line == 0) return (x == 0) ? 8'd128 : (x == 1) ? 8'd127 : (x == 9) ? 8'd200 : 8'd0;
        if (line == 3) return (x >= H_RES) ? 8'hFF : 8'h00;
        if (line == 5) return (x >= 96 && x <= 99) ? 8'hFF : 8'h00;
        return 8'h00;
    endfunction

    function automatic int line_len(input int kind, input int line);
        if (kind == 1 && line == 3) return H_RES + 2;
        if (kind == 1 && line == 5) return 100;
        return H_RES;
    endfunction

    // Write monitor / scoreboard.
    int         mon_kind  = 0;
    logic       clr_req   = 1'b0;
    int         wr_cnt    = 0;
    int         bad_cnt   = 0;
    int         order_bad = 0;
    int         zero_cnt  = 0;
    int         done_cnt  = 0;
    int         prev_addr = -1;
    int         first_addr = -1;
    int         last_addr  = -1;
    logic [7:0] mem [0:4095];

    always @(negedge clk) begin
        if (clr_req) begin
            wr_cnt = 0; bad_cnt = 0; order_bad = 0; zero_cnt = 0; done_cnt = 0;
            prev_addr = -1; first_addr = -1; last_addr = -1;
        end else begin
            if (o_mem_we) begin
                wr_cnt++;
                if (int'(o_mem_addr) <= prev_addr) order_bad++;
                if (first_addr < 0) first_addr = int'(o_mem_addr);
                prev_addr = int'(o_mem_addr);
                last_addr = int'(o_mem_addr);
                if (o_mem_addr == 12'd0) zero_cnt++;
                if (o_mem_wdata !== exp_byte(mon_kind, int'(o_mem_addr))) bad_cnt++;
                mem[o_mem_addr] = o_mem_wdata;
            end
            if (o_done) begin
                done_cnt++;
                prev_addr = -1;
            end
        end
    end

    task automatic clear_mon(input int kind);
        @(posedge clk);
        mon_kind = kind;
        clr_req  = 1'b1;
        @(posedge clk);
        clr_req  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_de = 1'b0; i_data = '0;
        end
    endtask

    task automatic arm_pulse;
        @(negedge clk); i_arm = 1'b1;
        @(negedge clk); i_arm = 1'b0;
    endtask

    task automatic vsync_pulse;
        @(negedge clk); i_vsync = 1'b1;
        idle(2);
        i_vsync = 1'b0;
        idle(2);
    endtask

    task automatic send_pixels(input int kind, input int line, input int from, input int to);
        for (int x = from; x < to; x++) begin
            @(negedge clk);
            i_hsync = 1'b0; i_de = 1'b1; i_data = pix_val(kind, line, x);
        end
    endtask

    task automatic end_line;
        @(negedge clk); i_de = 1'b0; i_data = '0; i_hsync = 1'b1;
        @(negedge clk); i_hsync = 1'b0;
    endtask

    task automatic send_line(input int kind, input int line);
        send_pixels(kind, line, 0, line_len(kind, line));
        end_line();
    endtask

    task automatic check_outs_zero(input string tag);
        check(tag, {o_busy, o_done, o_frame_err, o_mem_we, o_mem_addr, o_mem_wdata, o_edge_cnt}, 64'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int pre;
        idle(3);
        check_outs_zero("reset_outs");
        rstn = 1'b1;
        idle(2);
        check("idle_busy", o_busy, 1'b0);

`ifndef EDGE_CAPTURE_CONT_EN
        // Reset mid-capture on line 40.
        clear_mon(0);
        arm_pulse();
        check("arm_busy", o_busy, 1'b1);
        vsync_pulse();
        for (int y = 0; y < 40; y++) send_line(0, y);
        send_pixels(0, 40, 0, 85);
        @(negedge clk);
        i_de = 1'b0;
        rstn = 1'b0;
        #1;
        check_outs_zero("midcap_reset_outs");
        check("pre_reset_writes", wr_cnt, 890);
        pre = wr_cnt;
        send_pixels(0, 40, 0, 8);
        rstn = 1'b1;
        send_pixels(0, 40, 8, 85);
        end_line();
        for (int y = 41; y < 60; y++) send_line(0, y);
        idle(3);
        check("post_reset_writes", wr_cnt - pre, 0);
        check("post_reset_busy", o_busy, 1'b0);

        // Full all-255 frame; an arm in the middle of capture must be ignored.
        clear_mon(0);
        arm_pulse();
        vsync_pulse();
        for (int y = 0; y < V_RES; y++) begin
            if (y == 60) arm_pulse();
            send_line(0, y);
        end
        idle(3);
        check("full_writes", wr_cnt, 2640);
        check("full_data_bad", bad_cnt, 0);
        check("full_order_bad", order_bad, 0);
        check("full_first_addr", first_addr, 0);
        check("full_last_addr", last_addr, 2639);
        check("full_edge_cnt", o_edge_cnt, 20400);
        check("full_done", o_done, 1'b1);
        check("full_busy", o_busy, 1'b0);
        check("full_err", o_frame_err, 1'b0);

        // Pattern frame: thresholds on line 0, long line 3, short line 5.
        clear_mon(1);
        arm_pulse();
        vsync_pulse();
        for (int y = 0; y < V_RES; y++) begin
            send_line(1, y);
            if (y == 2) check("pat_err_clean", o_frame_err, 1'b0);
            if (y == 3) check("pat_long_err", o_frame_err, 1'b1);
        end
        idle(3);
        check("pat_writes", wr_cnt, 2631);
        check("pat_data_bad", bad_cnt, 0);
        check("pat_order_bad", order_bad, 0);
        check("pat_byte0", mem[0], 8'h01);
        check("pat_byte1", mem[1], 8'h02);
        check("pat_short_flush", mem[5 * BPL + 12], 8'h0F);
        check("pat_edge_cnt", o_edge_cnt, 6);
        check("pat_err", o_frame_err, 1'b1);
        check("pat_done", o_done, 1'b1);

        // Early vsync after 60 lines, then an unarmed frame.
        clear_mon(0);
        arm_pulse();
        check("rearm_err_clr", o_frame_err, 1'b0);
        check("rearm_cnt_clr", o_edge_cnt, 0);
        check("rearm_done_clr", o_done, 1'b0);
        vsync_pulse();
        for (int y = 0; y < 60; y++) send_line(0, y);
        vsync_pulse();
        idle(2);
        check("early_writes", wr_cnt, 1320);
        check("early_data_bad", bad_cnt, 0);
        check("early_err", o_frame_err, 1'b1);
        check("early_done", o_done, 1'b1);
        check("early_edge_cnt", o_edge_cnt, 10200);
        clear_mon(0);
        vsync_pulse();
        for (int y = 0; y < 10; y++) send_line(0, y);
        idle(3);
        check("unarmed_writes", wr_cnt, 0);
        check("unarmed_done", o_done, 1'b1);
`else
        // Continuous mode: one arm, two back-to-back frames.
        clear_mon(0);
        arm_pulse();
        check("arm_busy", o_busy, 1'b1);
        vsync_pulse();
        for (int y = 0; y < V_RES; y++) send_line(0, y);
        idle(2);
        check("cont_f1_done_pulses", done_cnt, 1);
        check("cont_f1_busy", o_busy, 1'b1);
        check("cont_f1_done_low", o_done, 1'b0);
        check("cont_f1_cnt_hold", o_edge_cnt, 20400);
        check("cont_f1_writes", wr_cnt, 2640);
        vsync_pulse();
        check("cont_f2_cnt_clr", o_edge_cnt, 0);
        for (int y = 0; y < V_RES; y++) send_line(0, y);
        idle(3);
        check("cont_done_pulses", done_cnt, 2);
        check("cont_writes", wr_cnt, 5280);
        check("cont_addr0_writes", zero_cnt, 2);
        check("cont_order_bad", order_bad, 0);
        check("cont_data_bad", bad_cnt, 0);
        check("cont_last_addr", last_addr, 2639);
        check("cont_edge_cnt", o_edge_cnt, 20400);
        check("cont_err", o_frame_err, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
